// File: rtl/dac_spi_master.sv
//-----------------------------------------------------------------------------
// dac_spi_master
//
// Serialises 24-bit DAC frame words from an AXI-Stream-style input onto a
// SPI-like DAC interface (SCLK / SYNC_n / SDIN), then strobes LDAC_n so the
// DAC moves the new code to its output.
//
// A frame is: SYNC_n low for CS_SETUP cycles, 24 SCLK periods (MSB first,
// each bit CLK_DIV cycles high then CLK_DIV cycles low, data changing with
// SCLK rising so the DAC can sample on the falling edge), CS_HOLD cycles with
// SYNC_n still low, then GAP cycles with SYNC_n high. The LDAC_n pulse sits
// at the start of GAP.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   24-bit frame word, bit 23 shifted out first
//   s_axis_tvalid  upstream word valid
//   s_axis_tready  registered ready, high only in IDLE
//   dac_sclk       SPI clock, idles low
//   dac_sync_n     frame select, active-low
//   dac_sdin       serial data, forced low while dac_sync_n is high
//   dac_ldac_n     load-DAC strobe, active-low
//   busy           high in every state except IDLE
//   frame_done     one-cycle pulse on the first GAP cycle of each frame
//
// State table
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | ready for a word; SYNC_n high, SCLK low
//   SETUP   | SYNC_n low, bit 23 on SDIN, waiting CS_SETUP cycles
//   SHIFT   | 24 SCLK periods, bit counter 23 down to 0
//   HOLD    | SYNC_n low after the last falling edge, SDIN holds bit 0
//   GAP     | SYNC_n high, frame_done pulse, LDAC_n pulse, then IDLE
//-----------------------------------------------------------------------------
module dac_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int GAP        = 4,
    parameter int LDAC_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_sdin,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        frame_done
);

    localparam int CNT_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // Timers are loaded with (length - 1) and terminate at zero, so a
    // phase of N cycles spends exactly N cycles in its state.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] LDAC_LD  = (LDAC_PULSE > 0) ? CNT_W'(LDAC_PULSE - 1) : '0;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] ldac_tmr;
    logic [4:0]       bit_cnt;
    logic [23:0]      shreg;
    logic             xfer;

    assign xfer = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tmr           <= '0;
            ldac_tmr      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            s_axis_tready <= 1'b0;
            dac_sclk      <= 1'b0;
            dac_sync_n    <= 1'b1;
            dac_sdin      <= 1'b0;
            dac_ldac_n    <= 1'b1;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        shreg         <= s_axis_tdata;
                        state         <= S_SETUP;
                        tmr           <= SETUP_LD;
                        s_axis_tready <= 1'b0;
                        dac_sync_n    <= 1'b0;
                        dac_sdin      <= s_axis_tdata[23];
                        busy          <= 1'b1;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        s_axis_tready <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (tmr == '0) begin
                        state    <= S_SHIFT;
                        tmr      <= HALF_LD;
                        bit_cnt  <= 5'd23;
                        dac_sclk <= 1'b1;
                        dac_sdin <= shreg[23];
                    end else begin
                        tmr <= tmr - ONE;
                    end
                end

                S_SHIFT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - ONE;
                    end else if (dac_sclk) begin
                        // High half done: falling edge, DAC samples SDIN here.
                        dac_sclk <= 1'b0;
                        tmr      <= HALF_LD;
                    end else if (bit_cnt == 5'd0) begin
                        // Low half of bit 0 done; SDIN keeps bit 0 into HOLD.
                        state <= S_HOLD;
                        tmr   <= HOLD_LD;
                    end else begin
                        // Next bit goes out together with the rising edge.
                        bit_cnt  <= bit_cnt - 5'd1;
                        shreg    <= {shreg[22:0], 1'b0};
                        dac_sdin <= shreg[22];
                        dac_sclk <= 1'b1;
                        tmr      <= HALF_LD;
                    end
                end

                S_HOLD: begin
                    if (tmr == '0) begin
                        state      <= S_GAP;
                        tmr        <= GAP_LD;
                        dac_sync_n <= 1'b1;
                        dac_sdin   <= 1'b0;
                        frame_done <= 1'b1;
                        if (LDAC_PULSE > 0) begin
                            dac_ldac_n <= 1'b0;
                            ldac_tmr   <= LDAC_LD;
                        end
                    end else begin
                        tmr <= tmr - ONE;
                    end
                end

                S_GAP: begin
                    // GAP >= LDAC_PULSE, so the strobe always ends by IDLE.
                    if (!dac_ldac_n) begin
                        if (ldac_tmr == '0) begin
                            dac_ldac_n <= 1'b1;
                        end else begin
                            ldac_tmr <= ldac_tmr - ONE;
                        end
                    end
                    if (tmr == '0) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        s_axis_tready <= 1'b1;
                    end else begin
                        tmr <= tmr - ONE;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    s_axis_tready <= 1'b0;
                    dac_sclk      <= 1'b0;
                    dac_sync_n    <= 1'b1;
                    dac_sdin      <= 1'b0;
                    dac_ldac_n    <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_master.sv
//-----------------------------------------------------------------------------
// tb_dac_spi_master
//
// Directed bench for dac_spi_master. u_dut runs with default parameters,
// u_fast with the minimum timing (CLK_DIV=1, all gaps 1, LDAC disabled).
// Negedge monitors decode the serial stream at SCLK falling edges and
// collect per-frame data, timing and protocol violations.
//-----------------------------------------------------------------------------
module tb_dac_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        dac_sclk, dac_sync_n, dac_sdin, dac_ldac_n, busy, frame_done;

    logic [23:0] tdata1 = '0;
    logic        tvalid1 = 1'b0;
    logic        tready1;
    logic        sclk1, sync1, sdin1, ldac1, busy1, done1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dac_spi_master u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dac_sclk      (dac_sclk),
        .dac_sync_n    (dac_sync_n),
        .dac_sdin      (dac_sdin),
        .dac_ldac_n    (dac_ldac_n),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    dac_spi_master #(
        .CLK_DIV    (1),
        .CS_SETUP   (1),
        .CS_HOLD    (1),
        .GAP        (1),
        .LDAC_PULSE (0)
    ) u_fast (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata1),
        .s_axis_tvalid (tvalid1),
        .s_axis_tready (tready1),
        .dac_sclk      (sclk1),
        .dac_sync_n    (sync1),
        .dac_sdin      (sdin1),
        .dac_ldac_n    (ldac1),
        .busy          (busy1),
        .frame_done    (done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor for u_dut ----------------
    logic        mon_clr = 1'b1;
    int          cyc = 0;
    logic        p_sclk, p_sdin, p_sync, p_tready;
    logic [23:0] m_word;
    int          m_bits, m_len;
    int          rises, falls, dones, ldac_low, nfr;
    int          sync_hi_run, min_gap, tready_rise_cyc;
    logic        seen_frame;
    int          v_fall = 0, v_sdin = 0, v_sclk = 0;
    logic [23:0] fr_word[$];
    int          fr_bits[$];
    int          fr_len[$];
    int          xfer_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            m_word = '0; m_bits = 0; m_len = 0;
            rises = 0; falls = 0; dones = 0; ldac_low = 0; nfr = 0;
            sync_hi_run = 0; min_gap = 1000; tready_rise_cyc = 0;
            seen_frame = 1'b0;
            fr_word.delete(); fr_bits.delete(); fr_len.delete(); xfer_cyc.delete();
        end else begin
            if (dac_sync_n) begin
                if (dac_sdin) v_sdin++;
                if (dac_sclk) v_sclk++;
            end
            if (p_sync && !dac_sync_n) begin
                if (seen_frame && sync_hi_run < min_gap) min_gap = sync_hi_run;
                m_word = '0; m_bits = 0; m_len = 0; sync_hi_run = 0;
            end
            if (!p_sclk && dac_sclk) rises++;
            if (p_sclk && !dac_sclk) begin
                falls++;
                m_word = {m_word[22:0], p_sdin};
                m_bits++;
                if (dac_sdin !== p_sdin) v_fall++;
            end
            if (!dac_sync_n) m_len++;
            if (!p_sync && dac_sync_n) begin
                fr_word.push_back(m_word);
                fr_bits.push_back(m_bits);
                fr_len.push_back(m_len);
                nfr++;
                seen_frame = 1'b1;
                sync_hi_run = 0;
            end
            if (dac_sync_n) sync_hi_run++;
            if (frame_done) dones++;
            if (!dac_ldac_n) ldac_low++;
            if (s_axis_tvalid && s_axis_tready) xfer_cyc.push_back(cyc);
            if (!p_tready && s_axis_tready) tready_rise_cyc = cyc;
        end
        p_sclk = dac_sclk; p_sdin = dac_sdin; p_sync = dac_sync_n; p_tready = s_axis_tready;
    end

    // ---------------- monitor for u_fast ----------------
    int          cyc1 = 0;
    logic        q_sclk1, q_sdin1, q_sync1;
    logic [23:0] word1;
    int          len1, rises1, dones1, ldac_low1, hi_run1, max_hi_run1;
    int          v1 = 0;
    logic [23:0] fr1_word[$];
    int          fr1_len[$];
    int          xfer1[$];

    always @(negedge clk) begin
        cyc1++;
        if (mon_clr) begin
            word1 = '0; len1 = 0; rises1 = 0; dones1 = 0; ldac_low1 = 0;
            hi_run1 = 0; max_hi_run1 = 0;
            fr1_word.delete(); fr1_len.delete(); xfer1.delete();
        end else begin
            if (sync1 && (sdin1 || sclk1)) v1++;
            if (p_sync_fall1(q_sync1, sync1)) begin word1 = '0; len1 = 0; end
            if (!q_sclk1 && sclk1) rises1++;
            if (q_sclk1 && !sclk1) begin
                word1 = {word1[22:0], q_sdin1};
                if (sdin1 !== q_sdin1) v1++;
            end
            if (sclk1) hi_run1++; else hi_run1 = 0;
            if (hi_run1 > max_hi_run1) max_hi_run1 = hi_run1;
            if (!sync1) len1++;
            if (!q_sync1 && sync1) begin fr1_word.push_back(word1); fr1_len.push_back(len1); end
            if (done1) dones1++;
            if (!ldac1) ldac_low1++;
            if (tvalid1 && tready1) xfer1.push_back(cyc1);
        end
        q_sclk1 = sclk1; q_sdin1 = sdin1; q_sync1 = sync1;
    end

    function automatic logic p_sync_fall1(input logic prev, input logic now);
        return (prev === 1'b1) && (now === 1'b0);
    endfunction

    function automatic logic [31:0] q_word(input int i);
        return (i < fr_word.size()) ? 32'(fr_word[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_bits(input int i);
        return (i < fr_bits.size()) ? 32'(fr_bits[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_len(input int i);
        return (i < fr_len.size()) ? 32'(fr_len[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q_xfer(input int i);
        return (i < xfer_cyc.size()) ? 32'(xfer_cyc[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q1_word(input int i);
        return (i < fr1_word.size()) ? 32'(fr1_word[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q1_len(input int i);
        return (i < fr1_len.size()) ? 32'(fr1_len[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] q1_xfer(input int i);
        return (i < xfer1.size()) ? 32'(xfer1[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_ready0(input string tag, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!s_axis_tready && n < budget);
        check(tag, 32'(s_axis_tready), 32'd1);
    endtask

    task automatic wait_ready1(input string tag, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!tready1 && n < budget);
        check(tag, 32'(tready1), 32'd1);
    endtask

    task automatic wait_frames(input int want, input int budget);
        int n = 0;
        while (nfr < want && n < budget) begin @(negedge clk); n++; end
        check("frame_wait", 32'(nfr), 32'(want));
    endtask

    // Presents one word, waits for the handshake edge, then drops tvalid
    // and scribbles tdata to show it is ignored while tvalid is low.
    task automatic send_word(input logic [23:0] d);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        wait_ready0("send_ready", 500);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 24'($urandom);
    endtask

    initial begin
        int bad;

        // ---- reset ----
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'({s_axis_tready, dac_sclk, dac_sync_n, dac_sdin,
                                    dac_ldac_n, busy, frame_done}), 32'b0010100);
        check("reset_outputs_fast", 32'({tready1, sclk1, sync1, sdin1, ldac1, busy1, done1}),
              32'b0010100);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("tready_before_edge", 32'(s_axis_tready), 32'd0);
        @(posedge clk); #1;
        check("tready_first_edge", 32'(s_axis_tready), 32'd1);
        check("tready_first_edge_fast", 32'(tready1), 32'd1);

        // ---- idle for 100 cycles with tvalid low ----
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dac_sync_n !== 1'b1 || dac_sclk !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b1)
                bad++;
            if (sync1 !== 1'b1 || sclk1 !== 1'b0 || busy1 !== 1'b0 || tready1 !== 1'b1)
                bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // ---- single word ----
        clear_mon();
        send_word(24'h200008);
        wait_frames(1, 400);
        repeat (12) @(negedge clk);
        check("single_word", q_word(0), 32'h200008);
        check("single_bits", q_bits(0), 32'd24);
        check("single_sync_low", q_len(0), 32'd196);
        check("single_rises", 32'(rises), 32'd24);
        check("single_falls", 32'(falls), 32'd24);
        check("single_done", 32'(dones), 32'd1);
        check("single_ldac_low", 32'(ldac_low), 32'd2);
        check("single_tready_return", 32'(tready_rise_cyc) - q_xfer(0), 32'd201);

        // ---- back-to-back with tvalid held high ----
        clear_mon();
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h1ABCDE;
        wait_ready0("b2b_ready0", 50);
        @(posedge clk); #1 s_axis_tdata = 24'h100000;
        repeat (50) @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        repeat (20) @(posedge clk);
        #1 s_axis_tvalid = 1'b1;
        @(negedge clk);
        wait_ready0("b2b_ready1", 300);
        @(posedge clk); #1 s_axis_tvalid = 1'b0;
        wait_frames(2, 400);
        repeat (12) @(negedge clk);
        check("b2b_word0", q_word(0), 32'h1ABCDE);
        check("b2b_word1", q_word(1), 32'h100000);
        check("b2b_xfers", 32'(xfer_cyc.size()), 32'd2);
        check("b2b_spacing", q_xfer(1) - q_xfer(0), 32'd201);
        check("b2b_sync_gap", 32'(min_gap), 32'd5);
        check("b2b_done", 32'(dones), 32'd2);

        // ---- reset mid-SHIFT at bit 10 ----
        clear_mon();
        send_word(24'h0F0F0F);
        begin
            int n = 0;
            while (falls < 14 && n < 400) begin @(negedge clk); n++; end
        end
        check("abort_reach_bit10", 32'(falls), 32'd14);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("abort_outputs", 32'({s_axis_tready, dac_sclk, dac_sync_n, dac_sdin,
                                        dac_ldac_n, busy, frame_done}), 32'b0010100);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("abort_tready_before_edge", 32'(s_axis_tready), 32'd0);
        @(posedge clk); #1;
        check("abort_tready_first_edge", 32'(s_axis_tready), 32'd1);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_no_ldac", 32'(ldac_low), 32'd0);
        check("abort_no_extra_fall", 32'(falls), 32'd14);
        clear_mon();
        send_word(24'h155555);
        wait_frames(1, 400);
        repeat (12) @(negedge clk);
        check("post_abort_word", q_word(0), 32'h155555);
        check("post_abort_bits", q_bits(0), 32'd24);
        check("post_abort_done", 32'(dones), 32'd1);

        // ---- minimum timing instance ----
        clear_mon();
        @(posedge clk); #1;
        tvalid1 = 1'b1;
        tdata1  = 24'hC3A55A;
        wait_ready1("fast_ready0", 50);
        @(posedge clk); #1 tdata1 = 24'h00FFFF;
        wait_ready1("fast_ready1", 100);
        @(posedge clk); #1 tvalid1 = 1'b0;
        repeat (80) @(negedge clk);
        check("fast_word0", q1_word(0), 32'hC3A55A);
        check("fast_word1", q1_word(1), 32'h00FFFF);
        check("fast_sync_low", q1_len(0), 32'd50);
        check("fast_period", q1_xfer(1) - q1_xfer(0), 32'd52);
        check("fast_rises", 32'(rises1), 32'd48);
        check("fast_sclk_high_run", 32'(max_hi_run1), 32'd1);
        check("fast_ldac_idle", 32'(ldac_low1), 32'd0);
        check("fast_done", 32'(dones1), 32'd2);

        // ---- protocol checks accumulated across all frames ----
        check("sdin_change_on_fall", 32'(v_fall), 32'd0);
        check("sdin_while_sync_high", 32'(v_sdin), 32'd0);
        check("sclk_while_sync_high", 32'(v_sclk), 32'd0);
        check("fast_protocol", 32'(v1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
